program_memory_arbiter: RTL and testbench
=========================================

PROGRAM_MEMORY_ARBITER -- requirements
Module: program_memory_arbiter

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 32, meaning the number of ROM words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the address and instruction width.
REQ-003 SHALL have parameter BASE_ADDRESS, default 32'h0040_0000, meaning the byte address of ROM word 0.
REQ-004 SHALL have these ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset.
- FetchReq  input  1  fetch-port request.
- FetchAddress  input  DATA_WIDTH  fetch byte address.
- FetchGrant  output  1  combinational; transfer occurs at an edge where FetchReq=1 and FetchGrant=1.
- FetchValid  output  1  one-cycle response pulse.
- FetchData  output  DATA_WIDTH  fetch response word.
- FetchError  output  1  qualifies FetchValid; the address was illegal.
- Flush  input  1  kills an in-flight fetch-port transaction.
- DataReq, DataAddress, DataGrant, DataValid, DataData, DataError: the same meanings and widths as the fetch port, for the load port.
- RomAddress  output  DATA_WIDTH  registered byte address to the ROM.
- RomInstruction  input  DATA_WIDTH  combinational ROM read data.

Function
REQ-005 SHALL be a 2-stage pipeline:
- Stage 1 (issue): RomAddress, Owner, Pending and Err registers.
- Stage 2 (response): the per-port Valid, Data and Error registers.
REQ-006 SHALL accept at most one transfer per edge, with sustained throughput of 1 transfer/cycle and no stall.
REQ-007 SHALL grant at most one port per cycle, combinationally:
- With only one Req high, that port is granted.
- With both Req high, the port indicated by the round-robin pointer Prio is granted.
REQ-008 SHALL, after each transfer, set Prio to the port that did not win; Prio is unchanged at edges with no transfer.
REQ-009 SHALL, at a transfer edge, load the stage-1 registers as follows:
- Owner = the winning port.
- Pending = 1.
- Err = illegal(Address).
- RomAddress = Address - BASE_ADDRESS when legal, otherwise 0.
REQ-010 SHALL, at an edge with no transfer, clear Pending and hold RomAddress.
REQ-011 SHALL treat an address as illegal when any of these holds:
- Address < BASE_ADDRESS.
- Address - BASE_ADDRESS > 4*MEMORY_DEPTH-4.
- Address[1:0] != 0.
REQ-012 SHALL, at each edge with Pending=1, set the owner's Valid to 1 and its Error to Err, and set its Data to RomInstruction when Err=0, otherwise to 0.
REQ-013 SHALL set the non-owner's Valid and Error to 0 at that same edge and leave its Data unchanged.
REQ-014 SHALL deassert both Valid outputs at an edge where Pending=0; Data holds its last value.
REQ-015 SHALL give a fixed latency: a transfer at edge N produces Valid/Data/Error for the whole cycle after edge N+1.
REQ-016 SHALL apply Flush when Flush=1 at edge N+1, Pending=1 and Owner=fetch: FetchValid and FetchError stay 0 and FetchData is unchanged.
REQ-017 SHALL NOT let Flush kill a data-port transaction or suppress a fetch transfer accepted at that same edge; that fetch completes normally one edge later.
REQ-018 SHALL perform address arithmetic modulo 2^DATA_WIDTH, with the out-of-range test done before subtraction so that no underflow aliases into legal space.
REQ-019 SHALL leave the behaviour of a requester that drops Req without a grant as no-op; requests are not latched.

Reset
REQ-020 SHALL, at any edge with reset=0, force the following, overriding any transfer or response in progress:
- RomAddress = 0, Owner = fetch, Pending = 0, Err = 0.
- Prio = fetch.
- FetchValid = DataValid = 0, FetchError = DataError = 0.
- FetchData = DataData = 0.
REQ-021 SHALL hold FetchGrant = DataGrant = 0 while reset=0; a transfer in flight when reset asserts is discarded and produces no Valid.

Verification
REQ-022 Reset: reset=0 for 2 edges with both Req=1 -> both Grants 0 throughout; all outputs 0; after release the first grant goes to the fetch port.
REQ-023 Single fetch: FetchAddress=32'h0040_0004 accepted at edge N -> RomAddress=32'h4 after N; FetchValid=1 and FetchData=rom[1] only in the cycle after N+1.
REQ-024 Contention: both Req held high for 6 cycles after reset -> grants alternate F,D,F,D,F,D; responses alternate one cycle later with no gaps.
REQ-025 Illegal data addresses 32'h0040_0002, 32'h003F_FFFC and 32'h0040_0080 (depth 32), each -> DataValid=1, DataError=1, DataData=0, RomAddress=0.
REQ-026 Flush: fetch accepted at N, Flush=1 and a new fetch accepted at N+1 -> no FetchValid after N+1; FetchValid for the second fetch after N+2; a concurrent data transaction is unaffected.

Source files
------------

// File: rtl/program_memory_arbiter_if.sv
// Bus bundle between the two requesters (fetch and load ports) and the
// program-memory arbiter, including the ROM address/data pair.
interface program_memory_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  FetchReq;
  logic [DATA_WIDTH-1:0] FetchAddress;
  logic                  FetchGrant;
  logic                  FetchValid;
  logic [DATA_WIDTH-1:0] FetchData;
  logic                  FetchError;
  logic                  Flush;

  logic                  DataReq;
  logic [DATA_WIDTH-1:0] DataAddress;
  logic                  DataGrant;
  logic                  DataValid;
  logic [DATA_WIDTH-1:0] DataData;
  logic                  DataError;

  logic [DATA_WIDTH-1:0] RomAddress;
  logic [DATA_WIDTH-1:0] RomInstruction;

  // Arbiter side.
  modport slave (
    input  FetchReq, FetchAddress, Flush, DataReq, DataAddress, RomInstruction,
    output FetchGrant, FetchValid, FetchData, FetchError,
    output DataGrant, DataValid, DataData, DataError, RomAddress
  );

  // Requester / ROM side.
  modport master (
    output FetchReq, FetchAddress, Flush, DataReq, DataAddress, RomInstruction,
    input  FetchGrant, FetchValid, FetchData, FetchError,
    input  DataGrant, DataValid, DataData, DataError, RomAddress
  );
endinterface

// File: rtl/program_memory_arbiter.sv
// Two-port round-robin arbiter in front of a combinational-read ROM:
// stage 1 issues the ROM address, stage 2 registers the per-port response.
module program_memory_arbiter #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  program_memory_arbiter_if.slave  bus
);

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;
  localparam logic [DATA_WIDTH-1:0] LAST_OFFSET = DATA_WIDTH'(4 * MEMORY_DEPTH - 4);

  // Port 0 is fetch, port 1 is data throughout.
  logic [1:0]            req;
  logic [DATA_WIDTH-1:0] addr [2];
  logic [1:0]            grant;

  logic                  rom_owner_winner;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_offset;
  logic                  addr_below;
  logic                  addr_beyond;
  logic                  addr_misaligned;
  logic                  addr_illegal;

  logic [DATA_WIDTH-1:0] rom_addr_reg, rom_addr_next;
  logic                  owner_reg,    owner_next;
  logic                  pending_reg,  pending_next;
  logic                  err_reg,      err_next;
  logic                  prio_reg,     prio_next;

  logic [1:0]            valid_out;
  logic [1:0]            error_out;
  logic [DATA_WIDTH-1:0] data_out [2];

  assign req     = {bus.DataReq, bus.FetchReq};
  assign addr[0] = bus.FetchAddress;
  assign addr[1] = bus.DataAddress;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      localparam logic PORT_ID = 1'(gi);
      localparam int   OTHER   = 1 - gi;
      // Grants are forced low during reset so nothing is accepted then.
      assign grant[gi] = reset && req[gi] && (!req[OTHER] || (prio_reg == PORT_ID));
    end
  endgenerate

  assign bus.FetchGrant = grant[0];
  assign bus.DataGrant  = grant[1];

  assign transfer         = |grant;
  assign rom_owner_winner = grant[1] ? PORT_DATA : PORT_FETCH;
  assign sel_addr         = grant[1] ? addr[1] : addr[0];

  // The below-base test gates the range test so a wrapped offset cannot look legal.
  assign sel_offset      = sel_addr - BASE_ADDRESS;
  assign addr_below      = (sel_addr < BASE_ADDRESS);
  assign addr_beyond     = !addr_below && (sel_offset > LAST_OFFSET);
  assign addr_misaligned = |sel_addr[1:0];
  assign addr_illegal    = addr_below || addr_beyond || addr_misaligned;

  always_comb begin
    rom_addr_next = rom_addr_reg;
    owner_next    = owner_reg;
    pending_next  = 1'b0;
    err_next      = err_reg;
    prio_next     = prio_reg;
    if (transfer) begin
      owner_next    = rom_owner_winner;
      pending_next  = 1'b1;
      err_next      = addr_illegal;
      rom_addr_next = addr_illegal ? '0 : sel_offset;
      prio_next     = ~rom_owner_winner;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rom_addr_reg <= '0;
      owner_reg    <= PORT_FETCH;
      pending_reg  <= 1'b0;
      err_reg      <= 1'b0;
      prio_reg     <= PORT_FETCH;
    end else begin
      rom_addr_reg <= rom_addr_next;
      owner_reg    <= owner_next;
      pending_reg  <= pending_next;
      err_reg      <= err_next;
      prio_reg     <= prio_next;
    end
  end

  assign bus.RomAddress = rom_addr_reg;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      localparam logic PORT_ID   = 1'(gi);
      localparam bit   FLUSHABLE = (gi == 0);

      logic                  valid_reg, valid_next;
      logic                  error_reg, error_next;
      logic [DATA_WIDTH-1:0] data_reg,  data_next;
      logic                  killed;

      // Only the fetch port can be flushed, and only its pending response.
      assign killed = FLUSHABLE && bus.Flush;

      always_comb begin
        valid_next = 1'b0;
        error_next = 1'b0;
        data_next  = data_reg;
        if (pending_reg && (owner_reg == PORT_ID) && !killed) begin
          valid_next = 1'b1;
          error_next = err_reg;
          data_next  = err_reg ? '0 : bus.RomInstruction;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          valid_reg <= 1'b0;
          error_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= valid_next;
          error_reg <= error_next;
          data_reg  <= data_next;
        end
      end

      assign valid_out[gi] = valid_reg;
      assign error_out[gi] = error_reg;
      assign data_out[gi]  = data_reg;
    end
  endgenerate

  assign bus.FetchValid = valid_out[0];
  assign bus.FetchError = error_out[0];
  assign bus.FetchData  = data_out[0];
  assign bus.DataValid  = valid_out[1];
  assign bus.DataError  = error_out[1];
  assign bus.DataData   = data_out[1];

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Directed bench for program_memory_arbiter with a behavioural ROM whose
// word i holds 32'hC0DE_0000 + i.
module tb_program_memory_arbiter;

  localparam int          DW    = 32;
  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_memory_arbiter_if #(.DATA_WIDTH(DW)) bus();

  program_memory_arbiter #(
    .MEMORY_DEPTH(DEPTH),
    .DATA_WIDTH  (DW),
    .BASE_ADDRESS(BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] rom [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) rom[i] = 32'hC0DE_0000 + 32'(i);
  assign bus.RomInstruction = rom[bus.RomAddress[6:2]];

  int pass_count  = 0;
  int check_count = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.FetchReq = 1'b1; bus.FetchAddress = BASE + 32'h8;
    bus.DataReq  = 1'b1; bus.DataAddress  = BASE + 32'h10;
    bus.Flush    = 1'b0;
    for (int e = 0; e < 2; e++) begin
      #1;
      check_count++; if (bus.FetchGrant !== 1'b0) $display("FAIL rst_fgrant got=%b exp=0", bus.FetchGrant); else pass_count++;
      check_count++; if (bus.DataGrant !== 1'b0) $display("FAIL rst_dgrant got=%b exp=0", bus.DataGrant); else pass_count++;
      tick();
      check_count++; if (bus.FetchValid !== 1'b0) $display("FAIL rst_fvalid got=%b exp=0", bus.FetchValid); else pass_count++;
      check_count++; if (bus.DataValid !== 1'b0) $display("FAIL rst_dvalid got=%b exp=0", bus.DataValid); else pass_count++;
      check_count++; if (bus.FetchError !== 1'b0) $display("FAIL rst_ferr got=%b exp=0", bus.FetchError); else pass_count++;
      check_count++; if (bus.DataError !== 1'b0) $display("FAIL rst_derr got=%b exp=0", bus.DataError); else pass_count++;
      check_count++; if (bus.FetchData !== 32'h0) $display("FAIL rst_fdata got=%h exp=0", bus.FetchData); else pass_count++;
      check_count++; if (bus.DataData !== 32'h0) $display("FAIL rst_ddata got=%h exp=0", bus.DataData); else pass_count++;
      check_count++; if (bus.RomAddress !== 32'h0) $display("FAIL rst_romaddr got=%h exp=0", bus.RomAddress); else pass_count++;
      $display("txn reset edge %0d", e);
    end
    reset = 1'b1;
    #1;
    check_count++; if (bus.FetchGrant !== 1'b1) $display("FAIL rst_first_fgrant got=%b exp=1", bus.FetchGrant); else pass_count++;
    check_count++; if (bus.DataGrant !== 1'b0) $display("FAIL rst_first_dgrant got=%b exp=0", bus.DataGrant); else pass_count++;
  endtask

  task automatic test_contention;
    logic exp_f, exp_d;
    logic [31:0] exp_ra;
    for (int k = 0; k <= 6; k++) begin
      if (k == 6) begin bus.FetchReq = 1'b0; bus.DataReq = 1'b0; end
      #1;
      exp_f = (k < 6) && (k % 2 == 0);
      exp_d = (k < 6) && (k % 2 == 1);
      check_count++; if (bus.FetchGrant !== exp_f) $display("FAIL cont_fgrant k=%0d got=%b exp=%b", k, bus.FetchGrant, exp_f); else pass_count++;
      check_count++; if (bus.DataGrant !== exp_d) $display("FAIL cont_dgrant k=%0d got=%b exp=%b", k, bus.DataGrant, exp_d); else pass_count++;
      tick();
      exp_ra = exp_f ? 32'h8 : 32'h10;
      check_count++; if (bus.RomAddress !== exp_ra) $display("FAIL cont_romaddr k=%0d got=%h exp=%h", k, bus.RomAddress, exp_ra); else pass_count++;
      if (k >= 1) begin
        check_count++; if (bus.FetchValid !== ((k - 1) % 2 == 0)) $display("FAIL cont_fvalid k=%0d got=%b", k, bus.FetchValid); else pass_count++;
        check_count++; if (bus.DataValid !== ((k - 1) % 2 == 1)) $display("FAIL cont_dvalid k=%0d got=%b", k, bus.DataValid); else pass_count++;
        if ((k - 1) % 2 == 0) begin
          check_count++; if (bus.FetchData !== 32'hC0DE_0002) $display("FAIL cont_fdata k=%0d got=%h exp=c0de0002", k, bus.FetchData); else pass_count++;
        end else begin
          check_count++; if (bus.DataData !== 32'hC0DE_0004) $display("FAIL cont_ddata k=%0d got=%h exp=c0de0004", k, bus.DataData); else pass_count++;
        end
      end
      $display("txn contention k=%0d fg=%b dg=%b fv=%b dv=%b", k, exp_f, exp_d, bus.FetchValid, bus.DataValid);
    end
    tick();
    check_count++; if (bus.FetchValid !== 1'b0 || bus.DataValid !== 1'b0) $display("FAIL cont_idle_valid got=%b%b exp=00", bus.FetchValid, bus.DataValid); else pass_count++;
    check_count++; if (bus.FetchData !== 32'hC0DE_0002) $display("FAIL cont_fdata_hold got=%h exp=c0de0002", bus.FetchData); else pass_count++;
    check_count++; if (bus.DataData !== 32'hC0DE_0004) $display("FAIL cont_ddata_hold got=%h exp=c0de0004", bus.DataData); else pass_count++;
  endtask

  task automatic test_single_fetch;
    bus.FetchReq = 1'b1; bus.FetchAddress = BASE + 32'h4; bus.DataReq = 1'b0;
    #1;
    check_count++; if (bus.FetchGrant !== 1'b1) $display("FAIL sf_fgrant got=%b exp=1", bus.FetchGrant); else pass_count++;
    tick();
    bus.FetchReq = 1'b0;
    check_count++; if (bus.RomAddress !== 32'h4) $display("FAIL sf_romaddr got=%h exp=4", bus.RomAddress); else pass_count++;
    check_count++; if (bus.FetchValid !== 1'b0) $display("FAIL sf_early_valid got=%b exp=0", bus.FetchValid); else pass_count++;
    tick();
    check_count++; if (bus.FetchValid !== 1'b1) $display("FAIL sf_fvalid got=%b exp=1", bus.FetchValid); else pass_count++;
    check_count++; if (bus.FetchData !== 32'hC0DE_0001) $display("FAIL sf_fdata got=%h exp=c0de0001", bus.FetchData); else pass_count++;
    check_count++; if (bus.FetchError !== 1'b0) $display("FAIL sf_ferr got=%b exp=0", bus.FetchError); else pass_count++;
    check_count++; if (bus.DataValid !== 1'b0) $display("FAIL sf_dvalid got=%b exp=0", bus.DataValid); else pass_count++;
    $display("txn single_fetch addr=%h data=%h", BASE + 32'h4, bus.FetchData);
    tick();
    check_count++; if (bus.FetchValid !== 1'b0) $display("FAIL sf_late_valid got=%b exp=0", bus.FetchValid); else pass_count++;
    check_count++; if (bus.FetchData !== 32'hC0DE_0001) $display("FAIL sf_fdata_hold got=%h exp=c0de0001", bus.FetchData); else pass_count++;
    check_count++; if (bus.RomAddress !== 32'h4) $display("FAIL sf_romaddr_hold got=%h exp=4", bus.RomAddress); else pass_count++;
  endtask

  task automatic test_illegal_data;
    logic [31:0] addrs    [4] = '{32'h0040_0002, 32'h003F_FFFC, 32'h0040_0080, 32'h0040_007C};
    logic        exp_err  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_ra   [4] = '{32'h0, 32'h0, 32'h0, 32'h7C};
    logic [31:0] exp_data [4] = '{32'h0, 32'h0, 32'h0, 32'hC0DE_001F};
    for (int i = 0; i < 4; i++) begin
      bus.DataReq = 1'b1; bus.DataAddress = addrs[i];
      #1;
      check_count++; if (bus.DataGrant !== 1'b1) $display("FAIL ill_dgrant i=%0d got=%b exp=1", i, bus.DataGrant); else pass_count++;
      tick();
      bus.DataReq = 1'b0;
      check_count++; if (bus.RomAddress !== exp_ra[i]) $display("FAIL ill_romaddr i=%0d got=%h exp=%h", i, bus.RomAddress, exp_ra[i]); else pass_count++;
      tick();
      check_count++; if (bus.DataValid !== 1'b1) $display("FAIL ill_dvalid i=%0d got=%b exp=1", i, bus.DataValid); else pass_count++;
      check_count++; if (bus.DataError !== exp_err[i]) $display("FAIL ill_derr i=%0d got=%b exp=%b", i, bus.DataError, exp_err[i]); else pass_count++;
      check_count++; if (bus.DataData !== exp_data[i]) $display("FAIL ill_ddata i=%0d got=%h exp=%h", i, bus.DataData, exp_data[i]); else pass_count++;
      check_count++; if (bus.FetchValid !== 1'b0) $display("FAIL ill_fvalid i=%0d got=%b exp=0", i, bus.FetchValid); else pass_count++;
      $display("txn data addr=%h err=%b data=%h", addrs[i], bus.DataError, bus.DataData);
    end
  endtask

  task automatic test_flush;
    bus.FetchReq = 1'b1; bus.FetchAddress = BASE + 32'hC;
    #1;
    check_count++; if (bus.FetchGrant !== 1'b1) $display("FAIL fl_fgrant0 got=%b exp=1", bus.FetchGrant); else pass_count++;
    tick();
    check_count++; if (bus.RomAddress !== 32'hC) $display("FAIL fl_romaddr0 got=%h exp=c", bus.RomAddress); else pass_count++;
    bus.FetchAddress = BASE + 32'h14; bus.Flush = 1'b1;
    #1;
    check_count++; if (bus.FetchGrant !== 1'b1) $display("FAIL fl_fgrant1 got=%b exp=1", bus.FetchGrant); else pass_count++;
    tick();
    bus.Flush = 1'b0; bus.FetchReq = 1'b0;
    check_count++; if (bus.FetchValid !== 1'b0) $display("FAIL fl_killed_valid got=%b exp=0", bus.FetchValid); else pass_count++;
    check_count++; if (bus.FetchError !== 1'b0) $display("FAIL fl_killed_err got=%b exp=0", bus.FetchError); else pass_count++;
    check_count++; if (bus.FetchData !== 32'hC0DE_0001) $display("FAIL fl_killed_data got=%h exp=c0de0001", bus.FetchData); else pass_count++;
    check_count++; if (bus.RomAddress !== 32'h14) $display("FAIL fl_romaddr1 got=%h exp=14", bus.RomAddress); else pass_count++;
    tick();
    check_count++; if (bus.FetchValid !== 1'b1) $display("FAIL fl_second_valid got=%b exp=1", bus.FetchValid); else pass_count++;
    check_count++; if (bus.FetchData !== 32'hC0DE_0005) $display("FAIL fl_second_data got=%h exp=c0de0005", bus.FetchData); else pass_count++;
    $display("txn flush second fetch data=%h", bus.FetchData);
    bus.DataReq = 1'b1; bus.DataAddress = BASE + 32'h18;
    tick();
    bus.DataReq = 1'b0; bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    check_count++; if (bus.DataValid !== 1'b1) $display("FAIL fl_data_valid got=%b exp=1", bus.DataValid); else pass_count++;
    check_count++; if (bus.DataData !== 32'hC0DE_0006) $display("FAIL fl_data_data got=%h exp=c0de0006", bus.DataData); else pass_count++;
    check_count++; if (bus.FetchValid !== 1'b0) $display("FAIL fl_data_fvalid got=%b exp=0", bus.FetchValid); else pass_count++;
    $display("txn flush data unaffected data=%h", bus.DataData);
  endtask

  task automatic test_reset_inflight;
    bus.FetchReq = 1'b1; bus.FetchAddress = BASE + 32'h8;
    tick();
    reset = 1'b0; bus.DataReq = 1'b1; bus.DataAddress = BASE + 32'h10;
    #1;
    check_count++; if (bus.FetchGrant !== 1'b0 || bus.DataGrant !== 1'b0) $display("FAIL rif_grants got=%b%b exp=00", bus.FetchGrant, bus.DataGrant); else pass_count++;
    tick();
    check_count++; if (bus.FetchValid !== 1'b0) $display("FAIL rif_fvalid got=%b exp=0", bus.FetchValid); else pass_count++;
    check_count++; if (bus.FetchData !== 32'h0 || bus.DataData !== 32'h0) $display("FAIL rif_data got=%h/%h exp=0/0", bus.FetchData, bus.DataData); else pass_count++;
    check_count++; if (bus.RomAddress !== 32'h0) $display("FAIL rif_romaddr got=%h exp=0", bus.RomAddress); else pass_count++;
    reset = 1'b1;
    #1;
    check_count++; if (bus.FetchGrant !== 1'b1) $display("FAIL rif_prio_fgrant got=%b exp=1", bus.FetchGrant); else pass_count++;
    check_count++; if (bus.DataGrant !== 1'b0) $display("FAIL rif_prio_dgrant got=%b exp=0", bus.DataGrant); else pass_count++;
    tick();
    bus.FetchReq = 1'b0; bus.DataReq = 1'b0;
    tick();
    check_count++; if (bus.FetchValid !== 1'b1) $display("FAIL rif_after_fvalid got=%b exp=1", bus.FetchValid); else pass_count++;
    check_count++; if (bus.FetchData !== 32'hC0DE_0002) $display("FAIL rif_after_fdata got=%h exp=c0de0002", bus.FetchData); else pass_count++;
    $display("txn reset in flight, refetch data=%h", bus.FetchData);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_fetch();
    test_illegal_data();
    test_flush();
    test_reset_inflight();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
